// File: rtl/pingpong_feature_buffer.sv
// Two-bank feature-map store: producer fills one bank while consumer reads the other.
// Writes commit at the accepting edge, reads return 1 cycle later; illegal requests are dropped and flag sticky err_o.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module pingpong_feature_buffer #(
   parameter int DATA_WIDTH    = `DATA_WIDTH,
   parameter int ROW_SIZE      = 12,
   parameter int ROWS          = 12,
   parameter int TOTAL_FEATURE = 20,
   parameter int IDX_WIDTH     = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_valid_i,
   input  logic [IDX_WIDTH-1:0]           wr_feature_idx_i,
   input  logic [IDX_WIDTH-1:0]           wr_row_i,
   input  logic [ROW_SIZE*DATA_WIDTH-1:0] wr_data_i,
   input  logic                           wr_image_fin_i,
   output logic                           wr_ready_o,
   input  logic                           rd_en_i,
   input  logic [IDX_WIDTH-1:0]           rd_feature_idx_i,
   input  logic [IDX_WIDTH-1:0]           rd_row_i,
   input  logic                           rd_image_fin_i,
   output logic                           rd_bank_ready_o,
   output logic                           rd_valid_o,
   output logic [ROW_SIZE*DATA_WIDTH-1:0] rd_data_o,
   output logic                           err_o
);

   localparam int ROW_W      = ROW_SIZE * DATA_WIDTH;
   localparam int BANK_WORDS = TOTAL_FEATURE * ROWS;
   localparam int DEPTH      = 2 * BANK_WORDS;
   localparam int ADDR_W     = $clog2(DEPTH);

   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        full;
   logic [1:0]        full_nxt;
   logic              rd_valid;
   logic [ROW_W-1:0]  rd_data;
   logic              err;

   logic              wr_in_range;
   logic              rd_in_range;
   logic              wr_acc;
   logic              rd_acc;
   logic              wr_fin_acc;
   logic              rd_fin_acc;
   logic              err_set;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;

   logic [ROW_W-1:0]  mem [DEPTH];

   function automatic logic [ADDR_W-1:0] word_addr(input logic bank,
                                                   input logic [IDX_WIDTH-1:0] feature,
                                                   input logic [IDX_WIDTH-1:0] row);
      return ADDR_W'(32'(bank) * BANK_WORDS + 32'(feature) * ROWS + 32'(row));
   endfunction

   assign wr_ready_o      = !full[wr_ptr];
   assign rd_bank_ready_o = full[rd_ptr];

   assign wr_in_range = (32'(wr_feature_idx_i) < TOTAL_FEATURE) && (32'(wr_row_i) < ROWS);
   assign rd_in_range = (32'(rd_feature_idx_i) < TOTAL_FEATURE) && (32'(rd_row_i) < ROWS);

   assign wr_acc     = wr_valid_i && wr_ready_o && wr_in_range;
   assign rd_acc     = rd_en_i && rd_bank_ready_o && rd_in_range;
   assign wr_fin_acc = wr_image_fin_i && wr_ready_o;
   assign rd_fin_acc = rd_image_fin_i && rd_bank_ready_o;

   assign err_set = (wr_valid_i && !(wr_ready_o && wr_in_range))
                 || (rd_en_i && !(rd_bank_ready_o && rd_in_range))
                 || (wr_image_fin_i && !wr_ready_o)
                 || (rd_image_fin_i && !rd_bank_ready_o);

   // Accesses use the pre-flip pointers, so a row written alongside its finish lands in the old bank.
   assign wr_addr = word_addr(wr_ptr, wr_feature_idx_i, wr_row_i);
   assign rd_addr = word_addr(rd_ptr, rd_feature_idx_i, rd_row_i);

   // Both finishes can never target the same bank legally, so set and clear never collide.
   always_comb begin
      full_nxt = full;
      if (wr_fin_acc) full_nxt[wr_ptr] = 1'b1;
      if (rd_fin_acc) full_nxt[rd_ptr] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         full   <= 2'b00;
         err    <= 1'b0;
      end else begin
         full <= full_nxt;
         if (wr_fin_acc) wr_ptr <= !wr_ptr;
         if (rd_fin_acc) rd_ptr <= !rd_ptr;
         if (err_set)    err    <= 1'b1;
      end
   end

   // Storage is deliberately not reset; stale rows are harmless once full is cleared.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_addr] <= wr_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) rd_data <= mem[rd_addr];
      end
   end

   assign rd_valid_o = rd_valid;
   assign rd_data_o  = rd_data;
   assign err_o      = err;

endmodule

// File: tb/tb_pingpong_feature_buffer.sv
// Bench for pingpong_feature_buffer: directed scenarios plus random traffic against an
// image-count model (banks are derived from how many images were finished on each side).
module tb_pingpong_feature_buffer;

   localparam int DW = 8;
   localparam int RS = 12;
   localparam int RW = 12;
   localparam int TF = 20;
   localparam int IW = 5;
   localparam int W  = RS * DW;
   localparam int DEPTH = 2 * TF * RW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid_i = 1'b0;
   logic [IW-1:0] wr_feature_idx_i = '0;
   logic [IW-1:0] wr_row_i = '0;
   logic [W-1:0]  wr_data_i = '0;
   logic          wr_image_fin_i = 1'b0;
   logic          wr_ready_o;
   logic          rd_en_i = 1'b0;
   logic [IW-1:0] rd_feature_idx_i = '0;
   logic [IW-1:0] rd_row_i = '0;
   logic          rd_image_fin_i = 1'b0;
   logic          rd_bank_ready_o;
   logic          rd_valid_o;
   logic [W-1:0]  rd_data_o;
   logic          err_o;

   pingpong_feature_buffer #(
      .DATA_WIDTH(DW), .ROW_SIZE(RS), .ROWS(RW), .TOTAL_FEATURE(TF), .IDX_WIDTH(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid_i(wr_valid_i), .wr_feature_idx_i(wr_feature_idx_i), .wr_row_i(wr_row_i),
      .wr_data_i(wr_data_i), .wr_image_fin_i(wr_image_fin_i), .wr_ready_o(wr_ready_o),
      .rd_en_i(rd_en_i), .rd_feature_idx_i(rd_feature_idx_i), .rd_row_i(rd_row_i),
      .rd_image_fin_i(rd_image_fin_i), .rd_bank_ready_o(rd_bank_ready_o),
      .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Reference model: images finished by producer (nw) and consumer (nr).
   logic [W-1:0] mmem [DEPTH];
   bit           mknown [DEPTH];
   int           nw, nr;
   bit           m_err, m_vld, m_known;
   logic [W-1:0] m_data;
   int           errors = 0;
   int           checks = 0;

   function automatic int maddr(int b, int f, int r);
      return b * TF * RW + f * RW + r;
   endfunction

   function automatic bit exp_wrdy();
      return (nw - nr) < 2;
   endfunction

   function automatic bit exp_rrdy();
      return (nw - nr) > 0;
   endfunction

   function automatic logic [W-1:0] pat(int f, int r);
      logic [W-1:0] v;
      for (int p = 0; p < RS; p++) v[p*DW +: DW] = DW'(f * RW + r + p * 7);
      return v;
   endfunction

   // One clock edge: model consumes the currently driven inputs, strobes drop afterwards.
   task automatic tick();
      bit wrdy, rrdy, win, rin;
      int wb, rb, a;
      wrdy = exp_wrdy();
      rrdy = exp_rrdy();
      wb = nw % 2;
      rb = nr % 2;
      win = (int'(wr_feature_idx_i) < TF) && (int'(wr_row_i) < RW);
      rin = (int'(rd_feature_idx_i) < TF) && (int'(rd_row_i) < RW);
      @(posedge clk);
      if (rd_en_i && rrdy && rin) begin
         a = maddr(rb, rd_feature_idx_i, rd_row_i);
         m_vld = 1; m_data = mmem[a]; m_known = mknown[a];
      end else m_vld = 0;
      if (wr_valid_i && wrdy && win) begin
         a = maddr(wb, wr_feature_idx_i, wr_row_i);
         mmem[a] = wr_data_i; mknown[a] = 1;
      end
      if ((wr_valid_i && !(wrdy && win)) || (rd_en_i && !(rrdy && rin)) ||
          (wr_image_fin_i && !wrdy) || (rd_image_fin_i && !rrdy)) m_err = 1;
      if (wr_image_fin_i && wrdy) nw++;
      if (rd_image_fin_i && rrdy) nr++;
      #1;
      wr_valid_i = 0; rd_en_i = 0; wr_image_fin_i = 0; rd_image_fin_i = 0;
   endtask

   task automatic wr_row(int f, int r, logic [W-1:0] d);
      wr_valid_i = 1; wr_feature_idx_i = IW'(f); wr_row_i = IW'(r); wr_data_i = d;
      tick();
   endtask

   task automatic rd_row(int f, int r);
      rd_en_i = 1; rd_feature_idx_i = IW'(f); rd_row_i = IW'(r);
      tick();
   endtask

   task automatic apply_reset();
      rst_n = 0;
      nw = 0; nr = 0; m_err = 0; m_vld = 0; m_data = '0; m_known = 1;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready_o); end
      checks++; if (rd_bank_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", rd_bank_ready_o); end
      checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid_o); end
      checks++; if (rd_data_o !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
      release_reset();
   endtask

   task automatic test_fill_and_read();
      for (int f = 0; f < TF; f++)
         for (int r = 0; r < RW; r++) wr_row(f, r, pat(f, r));
      checks++; if (rd_bank_ready_o !== 1'b0) begin errors++; $display("FAIL fill_not_ready: got %b want 0", rd_bank_ready_o); end
      wr_image_fin_i = 1; tick();
      checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL fill_wr_ready: got %b want 1", wr_ready_o); end
      checks++; if (rd_bank_ready_o !== 1'b1) begin errors++; $display("FAIL fill_rd_ready: got %b want 1", rd_bank_ready_o); end
      rd_row(7, 3);
      checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL fill_rd_valid: got %b want 1", rd_valid_o); end
      checks++; if (rd_data_o !== pat(7, 3)) begin errors++; $display("FAIL fill_rd_data: got %h want %h", rd_data_o, pat(7, 3)); end
      tick();
      checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL idle_rd_valid: got %b want 0", rd_valid_o); end
      checks++; if (rd_data_o !== pat(7, 3)) begin errors++; $display("FAIL hold_rd_data: got %h want %h", rd_data_o, pat(7, 3)); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL fill_err: got %b want 0", err_o); end
   endtask

   // Image 1 goes into bank 1 while image 0 is streamed out of bank 0 every cycle.
   task automatic test_pingpong();
      for (int f = 0; f < TF; f++)
         for (int r = 0; r < RW; r++) begin
            wr_valid_i = 1; wr_feature_idx_i = IW'(f); wr_row_i = IW'(r);
            wr_data_i = {$urandom, $urandom, $urandom};
            rd_en_i = 1; rd_feature_idx_i = IW'($urandom_range(0, TF-1)); rd_row_i = IW'($urandom_range(0, RW-1));
            tick();
            checks++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== m_data) begin
               errors++; $display("FAIL overlap_read: got %b/%h want 1/%h", rd_valid_o, rd_data_o, m_data);
            end
         end
   endtask

   task automatic test_simul_fin();
      wr_image_fin_i = 1; rd_image_fin_i = 1; tick();
      checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL simfin_wr_ready: got %b want 1", wr_ready_o); end
      checks++; if (rd_bank_ready_o !== 1'b1) begin errors++; $display("FAIL simfin_rd_ready: got %b want 1", rd_bank_ready_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL simfin_err: got %b want 0", err_o); end
      for (int i = 0; i < 8; i++) begin
         rd_row($urandom_range(0, TF-1), $urandom_range(0, RW-1));
         checks++;
         if (rd_valid_o !== 1'b1 || rd_data_o !== m_data) begin
            errors++; $display("FAIL bank1_read: got %b/%h want 1/%h", rd_valid_o, rd_data_o, m_data);
         end
      end
   endtask

   task automatic test_both_full();
      for (int f = 0; f < TF; f++)
         for (int r = 0; r < RW; r++) wr_row(f, r, {$urandom, $urandom, $urandom});
      wr_image_fin_i = 1; tick();
      checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b want 0", wr_ready_o); end
      wr_row(4, 5, {3{32'hDEADBEEF}});
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL full_err: got %b want 1", err_o); end
      rd_row(4, 5);
      checks++; if (rd_data_o !== m_data) begin errors++; $display("FAIL full_intact: got %h want %h", rd_data_o, m_data); end
      rd_image_fin_i = 1; tick();
      checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL refree_wr_ready: got %b want 1", wr_ready_o); end
      rd_row(4, 5);
      checks++; if (rd_data_o !== m_data) begin errors++; $display("FAIL image2_read: got %h want %h", rd_data_o, m_data); end
   endtask

   task automatic test_out_of_range();
      logic [W-1:0] held;
      apply_reset(); release_reset();
      wr_row(0, 0, pat(0, 0));
      wr_image_fin_i = 1; tick();
      rd_row(0, 0);
      held = rd_data_o;
      rd_row(0, 12);
      checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL oor_rd_valid: got %b want 0", rd_valid_o); end
      checks++; if (rd_data_o !== held) begin errors++; $display("FAIL oor_rd_hold: got %h want %h", rd_data_o, held); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", err_o); end
      // Feature 20 of bank 0 would alias bank 1 feature 0 row 0 without the range guard.
      apply_reset(); release_reset();
      wr_image_fin_i = 1; tick();
      wr_row(0, 0, {3{32'h12345678}});
      wr_image_fin_i = 1; tick();
      rd_image_fin_i = 1; tick();
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL oor_pre_err: got %b want 0", err_o); end
      wr_row(20, 0, {3{32'hCAFEF00D}});
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", err_o); end
      rd_row(0, 0);
      checks++; if (rd_data_o !== {3{32'h12345678}}) begin errors++; $display("FAIL oor_wr_intact: got %h want %h", rd_data_o, {3{32'h12345678}}); end
   endtask

   task automatic test_reset_midwrite();
      apply_reset(); release_reset();
      for (int r = 0; r < RW; r++) wr_row(1, r, {$urandom, $urandom, $urandom});
      wr_image_fin_i = 1; tick();
      rd_row(1, 2);
      for (int r = 0; r < 4; r++) wr_row(2, r, {$urandom, $urandom, $urandom});
      wr_valid_i = 1; wr_feature_idx_i = 5; wr_row_i = 5;
      apply_reset();
      wr_valid_i = 0;
      checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_wr_ready: got %b want 1", wr_ready_o); end
      checks++; if (rd_bank_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_rd_ready: got %b want 0", rd_bank_ready_o); end
      checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid: got %b want 0", rd_valid_o); end
      checks++; if (rd_data_o !== '0) begin errors++; $display("FAIL midrst_rd_data: got %h want 0", rd_data_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err_o); end
      release_reset();
      checks++; if (rd_bank_ready_o !== 1'b0) begin errors++; $display("FAIL postrst_rd_ready: got %b want 0", rd_bank_ready_o); end
   endtask

   task automatic test_random();
      apply_reset(); release_reset();
      for (int i = 0; i < 1500; i++) begin
         wr_valid_i = ($urandom_range(0, 3) != 0);
         wr_feature_idx_i = IW'($urandom_range(0, TF));
         wr_row_i = IW'($urandom_range(0, RW));
         wr_data_i = {$urandom, $urandom, $urandom};
         wr_image_fin_i = ($urandom_range(0, 24) == 0);
         rd_en_i = ($urandom_range(0, 2) != 0);
         rd_feature_idx_i = IW'($urandom_range(0, TF));
         rd_row_i = IW'($urandom_range(0, RW));
         rd_image_fin_i = ($urandom_range(0, 24) == 0);
         tick();
         checks++;
         if (wr_ready_o !== exp_wrdy() || rd_bank_ready_o !== exp_rrdy() ||
             rd_valid_o !== m_vld || err_o !== m_err) begin
            errors++;
            $display("FAIL rand_ctrl cyc %0d: got wr_rdy=%b rd_rdy=%b vld=%b err=%b want %b %b %b %b",
                     i, wr_ready_o, rd_bank_ready_o, rd_valid_o, err_o, exp_wrdy(), exp_rrdy(), m_vld, m_err);
         end
         if (m_known) begin
            checks++;
            if (rd_data_o !== m_data) begin
               errors++; $display("FAIL rand_data cyc %0d: got %h want %h", i, rd_data_o, m_data);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mknown[i] = 0;
      #2;
      test_reset();
      test_fill_and_read();
      test_pingpong();
      test_simul_fin();
      test_both_full();
      test_out_of_range();
      test_reset_midwrite();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
